// File: rtl/adder_pkg.sv
// Shared constants and payload layout for the pipelined adder.
// Optional signed-overflow output is enabled with ADDER_PIPE_OVF_EN.
package adder_pkg;

    localparam int ADDER_WIDTH  = 32;
    localparam int ADDER_STAGES = 4;

    // Per-stage payload at the default width; modules re-declare the same
    // layout locally so it can follow their WIDTH parameter.
    typedef struct packed {
        logic                   valid;
        logic                   carry;
        logic [ADDER_WIDTH-1:0] sum;
        logic [ADDER_WIDTH-1:0] a;
        logic [ADDER_WIDTH-1:0] b;
    } payload_t;

    function automatic int payload_bits(input int width);
        return 2 + 3 * width;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide slice of the pipelined adder: slice add plus the stage's
// valid/payload register, loaded whenever the next stage can take data.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH,
    parameter int STAGES = ADDER_STAGES,
    parameter int IDX    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [payload_bits(WIDTH)-1:0] up_i,
    input  logic                           dn_ready_i,
    output logic                           ready_o,
    output logic [payload_bits(WIDTH)-1:0] dn_o
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LO    = IDX * CHUNK;

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t           up;
    stage_t           stage_d;
    stage_t           stage_q;
    logic [CHUNK:0]   slice_sum;

    assign up = up_i;

    // NOTE: every variable gets a full default first so no path leaves it unassigned (no latch).
    always_comb begin
        stage_d   = up;
        slice_sum = {1'b0, up.a[LO +: CHUNK]} + {1'b0, up.b[LO +: CHUNK]}
                  + {{CHUNK{1'b0}}, up.carry};
        stage_d.sum[LO +: CHUNK] = slice_sum[CHUNK-1:0];
        stage_d.carry            = slice_sum[CHUNK];
    end

    // Loading on an empty slot lets a bubble be overwritten even while stalled.
    assign ready_o = !stage_q.valid || dn_ready_i;

    // NOTE: state uses non-blocking assignment so all stages sample old values on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload is reset as well, because sum/cout must read zero while in reset.
            stage_q <= '0;
        end else if (ready_o) begin
            stage_q <= stage_d;
        end
    end

    assign dn_o = stage_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder, STAGES slices of WIDTH/STAGES bits, valid/ready
// on both sides with bubble collapse. Define ADDER_PIPE_OVF_EN to add port ovf.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH,
    parameter int STAGES = ADDER_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int PW = payload_bits(WIDTH);

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("adder_pipe: WIDTH must be >= 1 and an exact multiple of STAGES");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    logic [STAGES:0][PW-1:0] link;
    logic [STAGES:0]         rdy;
    stage_t                  head;
    stage_t                  tail;
    logic                    unused_operands;

    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.carry = cin;
        head.a     = a;
        head.b     = b;
    end

    assign link[0]     = head;
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_i       (link[k]),
            .dn_ready_i (rdy[k+1]),
            .ready_o    (rdy[k]),
            .dn_o       (link[k+1])
        );
    end

    // Held low during reset; otherwise a pure function of stage valids and out_ready.
    assign in_ready = rdy[0] && !rst;

    assign tail      = link[STAGES];
    assign out_valid = tail.valid;
    assign sum       = tail.sum;
    assign cout      = tail.carry;

`ifdef ADDER_PIPE_OVF_EN
    assign ovf = (tail.a[WIDTH-1] == tail.b[WIDTH-1]) && (tail.sum[WIDTH-1] != tail.a[WIDTH-1]);
`endif

    // Fully consumed operands reach the last stage only to be dropped.
    assign unused_operands = ^{tail.a, tail.b};

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed corners, streaming, stalls,
// bubbles, mid-stream reset, random traffic and a WIDTH/STAGES sweep.
module tb_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Whole-word reference: {ovf, cout, sum}.
    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] f;
        logic        o;
        f = {1'b0, x} + {1'b0, y} + {32'b0, c};
`ifdef ADDER_PIPE_OVF_EN
        o = (x[31] == y[31]) && (f[31] != x[31]);
`else
        o = 1'b0;
`endif
        return {o, f};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom % 8)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- main DUT, WIDTH=32 STAGES=4 ----------------
    logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, dut_ovf;
    logic [31:0] a, b, sum;

    adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_PIPE_OVF_EN
        ,
        .ovf       (dut_ovf)
`endif
    );
`ifndef ADDER_PIPE_OVF_EN
    assign dut_ovf = 1'b0;
`endif

    logic [33:0] exp_q[$];
    int          out_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) check("main_spurious_out", out_valid, 1'b0);
                else                   check("main_result", {dut_ovf, cout, sum}, exp_q[0]);
                if (out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model32(a, b, cin));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic corner(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic [33:0] want);
        int lat;
        out_ready = 1'b1;
        a = x; b = y; cin = c; in_valid = 1'b1;
        #1;
        check({nm, "_in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({nm, "_latency"}, lat, 4);
        check({nm, "_value"}, {dut_ovf, cout, sum}, want);
        step();
    endtask

    initial begin
        int acc;
        int cnt0;
        int t;
        logic want_bit;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Pin the reference model with hand-computed values.
        check("pin_wrap",  model32(32'hFFFF_FFFF, 32'h1, 1'b0), 34'h1_0000_0000);
        check("pin_cin",   model32(32'hFFFF_FFFE, 32'h2, 1'b1), 34'h1_0000_0001);
        check("pin_small", model32(32'd1234, 32'd4321, 1'b1), 34'd5556);
`ifdef ADDER_PIPE_OVF_EN
        check("pin_ovf_pos", model32(32'h7FFF_FFFF, 32'h1, 1'b0), 34'h2_8000_0000);
        check("pin_ovf_neg", model32(32'h8000_0000, 32'h8000_0000, 1'b0), 34'h3_0000_0000);
`else
        check("pin_no_ovf", model32(32'h7FFF_FFFF, 32'h1, 1'b0), 34'h0_8000_0000);
`endif

        // Reset state.
        repeat (3) step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'h0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", dut_ovf, 1'b0);
        rst = 1'b0;
        step();
        check("first_edge_in_ready", in_ready, 1'b1);

        // Corners with literal expectations.
        corner("corner_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 34'h1_0000_0000);
        corner("corner_cin",  32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 34'h1_0000_0001);
`ifdef ADDER_PIPE_OVF_EN
        corner("corner_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 34'h2_8000_0000);
`else
        corner("corner_msb",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 34'h0_8000_0000);
`endif

        // Streaming: 10 back-to-back, results on 10 consecutive cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 10);
            a = pick32(); b = pick32(); cin = 1'($urandom);
            #1;
            if (i < 10) check("stream_in_ready", in_ready, 1'b1);
            want_bit = (i >= 4 && i < 14);
            check($sformatf("stream_out_valid_%0d", i), out_valid, want_bit);
            step();
        end

        // Backpressure: continuous input, consumer stalled for 6 cycles.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a = $urandom(); b = $urandom(); cin = 1'($urandom);
            #1;
            want_bit = (i < 4);
            check($sformatf("bp_in_ready_%0d", i), in_ready, want_bit);
            if (in_ready) acc++;
            step();
        end
        check("bp_accepted", acc, 4);
        check("bp_held_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt0 = out_cnt;
        repeat (8) step();
        check("bp_drained", out_cnt - cnt0, 4);

        // Bubble collapse: inputs at 0 and 2, a third at 3, stall until 8.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i == 0 || i == 2 || i == 3);
            a = pick32(); b = pick32(); cin = 1'($urandom);
            #1;
            if (i >= 3) check($sformatf("bubble_in_ready_%0d", i), in_ready, 1'b1);
            if (i == 7) check("bubble_held_valid", out_valid, 1'b1);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt0 = out_cnt;
        repeat (8) step();
        check("bubble_drained", out_cnt - cnt0, 3);

        // Reset with three transactions in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = $urandom(); b = $urandom(); cin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("pre_rst_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_sum", sum, 32'h0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_no_stale", out_valid, 1'b0);
        end

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 6;
            a = pick32(); b = pick32(); cin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check("rand_drain_empty", exp_q.size(), 0);

        t = 0;
        while (!(g_sw[0].done && g_sw[1].done) && t < 3000) begin
            step();
            t++;
        end
        check("sweep_done", {g_sw[0].done, g_sw[1].done}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- parameter sweep: 8/1 and 64/8 ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sw
        localparam int SW = (g == 0) ? 8 : 64;
        localparam int SS = (g == 0) ? 1 : 8;

        logic          r, iv, ir, ov, ordy, c, co, so, done;
        logic [SW-1:0] x, y, s;
        logic [SW+1:0] q[$];

        adder_pipe #(.WIDTH(SW), .STAGES(SS)) u_dut (
            .clk       (clk),
            .rst       (r),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (x),
            .b         (y),
            .cin       (c),
            .out_valid (ov),
            .out_ready (ordy),
            .sum       (s),
            .cout      (co)
`ifdef ADDER_PIPE_OVF_EN
            ,
            .ovf       (so)
`endif
        );
`ifndef ADDER_PIPE_OVF_EN
        assign so = 1'b0;
`endif

        function automatic logic [SW+1:0] model_w(input logic [SW-1:0] p, input logic [SW-1:0] m,
                                                  input logic ci);
            logic [SW:0] f;
            logic        o;
            f = {1'b0, p} + {1'b0, m} + {{SW{1'b0}}, ci};
`ifdef ADDER_PIPE_OVF_EN
            o = (p[SW-1] == m[SW-1]) && (f[SW-1] != p[SW-1]);
`else
            o = 1'b0;
`endif
            return {o, f};
        endfunction

        always @(negedge clk) begin
            if (r) begin
                q.delete();
            end else begin
                if (ov) begin
                    if (q.size() == 0) check($sformatf("sweep_w%0d_spurious", SW), ov, 1'b0);
                    else               check($sformatf("sweep_w%0d_result", SW), {so, co, s}, q[0]);
                    if (ordy && q.size() != 0) void'(q.pop_front());
                end
                if (iv && ir) q.push_back(model_w(x, y, c));
            end
        end

        initial begin
            int lat;
            r = 1'b1; iv = 1'b0; ordy = 1'b0; x = '0; y = '0; c = 1'b0; done = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            r = 1'b0;
            x = SW'({$urandom(), $urandom()});
            y = SW'({$urandom(), $urandom()});
            c = 1'($urandom);
            iv = 1'b1;
            ordy = 1'b1;
            @(posedge clk);
            #1;
            iv = 1'b0;
            lat = 1;
            while (!ov && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("sweep_w%0d_latency", SW), lat, SS);
            for (int i = 0; i < 400; i++) begin
                iv   = ($urandom % 10) < 7;
                ordy = ($urandom % 10) < 6;
                x = ($urandom % 6 == 0) ? '1 : SW'({$urandom(), $urandom()});
                y = ($urandom % 6 == 0) ? '1 : SW'({$urandom(), $urandom()});
                c = 1'($urandom);
                @(posedge clk);
                #1;
            end
            iv = 1'b0;
            ordy = 1'b1;
            repeat (SS + 4) @(posedge clk);
            #1;
            check($sformatf("sweep_w%0d_drain_empty", SW), q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; SHALL be at least 1.
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an exact multiple of STAGES, checked at elaboration.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  operands on a, b, cin are valid.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in.
REQ-010 Port out_valid  output  1  sum, cout and ovf hold a valid result.
REQ-011 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 Port sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-013 Port cout  output  1  carry out of bit WIDTH-1.
REQ-014 Port ovf  output  1  signed (two's-complement) overflow; present only when ADDER_PIPE_OVF_EN is defined.

Function
REQ-015 Input transfer occurs on a clk edge with in_valid=1 and in_ready=1; output transfer occurs on a clk edge with out_valid=1 and out_ready=1.
REQ-016 Datapath: CHUNK = WIDTH/STAGES; stage k adds slice k (bits k*CHUNK up to (k+1)*CHUNK-1) plus the carry registered by stage k-1 (cin for stage 0).
REQ-017 Unprocessed upper operand slices and finished lower sum slices travel alongside their transaction through every stage.
REQ-018 Latency: a transaction accepted at edge N SHALL show out_valid=1 after edge N+STAGES-1, given no stall.
REQ-019 Throughput: one transaction per cycle while out_ready=1.
REQ-020 Each stage holds a valid bit; stage k loads when stage k+1 is empty or is transferring downstream on the same edge. Empty stages (bubbles) are therefore collapsed.
REQ-021 in_ready = stage 0 empty OR stage 0 advancing on the same edge; it SHALL be combinational from stage valids and out_ready only, never from in_valid.
REQ-022 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL hold stable.
REQ-023 Full pipeline with out_ready=0: in_ready=0, no transaction lost, duplicated or reordered.
REQ-024 Simultaneous input and output transfer on a full pipeline SHALL be accepted in the same cycle.
REQ-025 Results SHALL leave in acceptance order.
REQ-026 Wrap-around: carries out of the MSB go only to cout; sum wraps modulo 2^WIDTH.

Reset
REQ-027 While rst=1: all stage valid bits=0, out_valid=0, in_ready=0, sum=0, cout=0, ovf=0.
REQ-028 Asserting rst mid-operation discards all in-flight transactions; none emerge afterward.
REQ-029 The first edge after rst deasserts SHALL show in_ready=1.

Configuration
REQ-030 With macro ADDER_PIPE_OVF_EN defined, port ovf exists and ovf = (a[MSB]==b[MSB]) AND (sum[MSB]!=a[MSB]), carried with its transaction.
REQ-031 Without ADDER_PIPE_OVF_EN, port ovf and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Package adder_pkg holds: the default WIDTH and STAGES constants, and a per-stage payload struct typedef (valid, carry, partial sum, remaining operands).
REQ-033 Sub-module adder_stage implements one CHUNK-wide adder slice plus its valid/payload register and load enable; adder_pipe instantiates it STAGES times with a generate loop.

Verification (WIDTH=32, STAGES=4 unless stated)
REQ-034 Corners, out_ready=1. Each result SHALL appear 4 cycles after acceptance (the last case needs ADDER_PIPE_OVF_EN):
- 0xFFFFFFFF + 0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0.
- 0xFFFFFFFE + 0x00000002, cin=1 -> sum=0x00000001, cout=1.
- 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1.
REQ-035 Streaming: 10 back-to-back transfers, out_ready=1 -> 10 correct results on 10 consecutive cycles, in order, in_ready stays 1.
REQ-036 Backpressure: continuous input, out_ready=0 for 6 cycles -> exactly 4 accepted, in_ready=0, outputs stable; on release every result is correct with none dropped.
REQ-037 Bubble collapse: transfers at cycles 0 and 2, out_ready=0 until cycle 8 -> both held in the pipeline; the third input is accepted while the pipe is not full.
REQ-038 Reset mid-stream: rst pulses with 3 transactions in flight -> out_valid=0 immediately, and no stale result appears afterward.
REQ-039 Parameter sweep: WIDTH=8, STAGES=1 and WIDTH=64, STAGES=8 -> randomized results match a reference model, with latencies of 1 and 8 respectively.
